// File: rtl/keyload_ctrl.sv
// Key entry controller: assembles a 64-bit key from PS/2 scancodes into an
// 8-byte key register, handling break/extended prefixes, backspace and enter.
module keyload_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       load_start,
  input  logic       key_consumed,
  output logic       key_we,
  output logic [2:0] keyindex,
  output logic [7:0] key_data,
  output logic [3:0] key_count,
  output logic       busy,
  output logic       key_ready,
  output logic       cipher_start
);

  typedef enum logic [1:0] {IDLE, COLLECT, SKIP, READY} state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  state_t     state, state_nxt;
  logic [3:0] count_nxt;
  logic       we_nxt;
  logic [2:0] idx_nxt;
  logic [7:0] data_nxt;
  logic       cs_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      key_count    <= '0;
      key_we       <= 1'b0;
      keyindex     <= '0;
      key_data     <= '0;
      cipher_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      key_count    <= count_nxt;
      key_we       <= we_nxt;
      keyindex     <= idx_nxt;
      key_data     <= data_nxt;
      cipher_start <= cs_nxt;
    end
  end

  // load_start overrides everything, including the byte offered in the same cycle
  always_comb begin
    state_nxt = state;
    count_nxt = key_count;
    we_nxt    = 1'b0;
    idx_nxt   = keyindex;
    data_nxt  = key_data;
    cs_nxt    = 1'b0;
    if (load_start) begin
      state_nxt = COLLECT;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: ;
        COLLECT: begin
          if (ps2_valid) begin
            case (ps2_data)
              SC_BREAK: state_nxt = SKIP;
              SC_EXT:   ;
              SC_BKSP: begin
                if (key_count != 4'd0) count_nxt = key_count - 4'd1;
              end
              SC_ENTER: begin
                if (key_count == 4'd8) begin
                  state_nxt = READY;
                  cs_nxt    = 1'b1;
                end
              end
              default: begin
                if (key_count < 4'd8) begin
                  we_nxt    = 1'b1;
                  idx_nxt   = key_count[2:0];
                  data_nxt  = ps2_data;
                  count_nxt = key_count + 4'd1;
                end
              end
            endcase
          end
        end
        SKIP: begin
          if (ps2_valid) state_nxt = COLLECT;
        end
        READY: begin
          if (key_consumed) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy      = (state == COLLECT) || (state == SKIP);
  assign key_ready = (state == READY);

endmodule

// File: tb/tb_keyload_ctrl.sv
// Directed bench for keyload_ctrl: per-cycle vector table plus hand-written
// reset-abort sequences.
module tb_keyload_ctrl;
  logic       clk;
  logic       reset;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       load_start;
  logic       key_consumed;
  logic       key_we;
  logic [2:0] keyindex;
  logic [7:0] key_data;
  logic [3:0] key_count;
  logic       busy;
  logic       key_ready;
  logic       cipher_start;

  keyload_ctrl dut (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .load_start(load_start), .key_consumed(key_consumed), .key_we(key_we),
    .keyindex(keyindex), .key_data(key_data), .key_count(key_count),
    .busy(busy), .key_ready(key_ready), .cipher_start(cipher_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        v;
    logic [7:0]  d;
    logic        kc;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_vec;
  int unsigned n_fail;
  logic [18:0] outs;

  assign outs = {key_we, keyindex, key_data, key_count, busy, key_ready, cipher_start};

  function automatic logic [18:0] ex(logic we, logic [2:0] idx, logic [7:0] dat,
                                     logic [3:0] cnt, logic b, logic r, logic cs);
    return {we, idx, dat, cnt, b, r, cs};
  endfunction

  task automatic add(logic ld, logic v, logic [7:0] d, logic kc, logic [18:0] e);
    vec_t t;
    t.ld = ld; t.v = v; t.d = d; t.kc = kc; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(string name, logic [18:0] e);
    n_vec++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL %s: got we=%b idx=%0d data=%h cnt=%0d busy=%b rdy=%b cs=%b, expected we=%b idx=%0d data=%h cnt=%0d busy=%b rdy=%b cs=%b",
               name, outs[18], outs[17:15], outs[14:7], outs[6:3], outs[2], outs[1], outs[0],
               e[18], e[17:15], e[14:7], e[6:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic drive(logic ld, logic v, logic [7:0] d, logic kc);
    load_start = ld; ps2_valid = v; ps2_data = d; key_consumed = kc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] full [8];
    n_vec = 0;
    n_fail = 0;
    full[0] = 8'h11; full[1] = 8'h22; full[2] = 8'h33; full[3] = 8'h44;
    full[4] = 8'h55; full[5] = 8'h77; full[6] = 8'h88; full[7] = 8'h99;

    // IDLE ignores bytes, then full 8-byte entry with premature enter and ninth byte
    add(0, 1, 8'h11, 0, ex(0, 0, 8'h00, 0, 0, 0, 0));
    add(1, 0, 8'h00, 0, ex(0, 0, 8'h00, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      add(0, 1, full[i], 0, ex(1, 3'(i), full[i], 4'(i + 1), 1, 0, 0));
    add(0, 1, 8'h5A, 0, ex(0, 4, 8'h55, 5, 1, 0, 0));
    for (int i = 5; i < 8; i++)
      add(0, 1, full[i], 0, ex(1, 3'(i), full[i], 4'(i + 1), 1, 0, 0));
    add(0, 1, 8'hAB, 0, ex(0, 7, 8'h99, 8, 1, 0, 0));
    add(0, 0, 8'h00, 0, ex(0, 7, 8'h99, 8, 1, 0, 0));
    add(0, 1, 8'h5A, 0, ex(0, 7, 8'h99, 8, 0, 1, 1));
    add(0, 1, 8'h12, 0, ex(0, 7, 8'h99, 8, 0, 1, 0));
    add(0, 0, 8'h00, 1, ex(0, 7, 8'h99, 0, 0, 0, 0));
    add(0, 0, 8'h00, 1, ex(0, 7, 8'h99, 0, 0, 0, 0));
    // break prefix, extended prefix, backspace down to and below zero
    add(1, 0, 8'h00, 0, ex(0, 7, 8'h99, 0, 1, 0, 0));
    add(0, 1, 8'h1C, 0, ex(1, 0, 8'h1C, 1, 1, 0, 0));
    add(0, 1, 8'hF0, 0, ex(0, 0, 8'h1C, 1, 1, 0, 0));
    add(0, 1, 8'h1C, 0, ex(0, 0, 8'h1C, 1, 1, 0, 0));
    add(0, 1, 8'h32, 0, ex(1, 1, 8'h32, 2, 1, 0, 0));
    add(0, 1, 8'hE0, 0, ex(0, 1, 8'h32, 2, 1, 0, 0));
    add(0, 1, 8'h66, 0, ex(0, 1, 8'h32, 1, 1, 0, 0));
    add(0, 1, 8'h66, 0, ex(0, 1, 8'h32, 0, 1, 0, 0));
    add(0, 1, 8'h66, 0, ex(0, 1, 8'h32, 0, 1, 0, 0));
    add(0, 1, 8'h45, 0, ex(1, 0, 8'h45, 1, 1, 0, 0));
    // load_start beats a same-cycle byte; SKIP swallows even an enter code
    add(1, 1, 8'h56, 0, ex(0, 0, 8'h45, 0, 1, 0, 0));
    add(0, 1, 8'hF0, 0, ex(0, 0, 8'h45, 0, 1, 0, 0));
    add(0, 1, 8'h5A, 0, ex(0, 0, 8'h45, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'(i + 1), 0, ex(1, 3'(i), 8'(i + 1), 4'(i + 1), 1, 0, 0));
    add(0, 1, 8'h5A, 0, ex(0, 7, 8'h08, 8, 0, 1, 1));
    // same-cycle load_start and key_consumed in READY -> COLLECT
    add(1, 0, 8'h00, 1, ex(0, 7, 8'h08, 0, 1, 0, 0));
    add(0, 1, 8'h5A, 0, ex(0, 7, 8'h08, 0, 1, 0, 0));
    add(0, 0, 8'h00, 1, ex(0, 7, 8'h08, 0, 1, 0, 0));

    load_start = 0; ps2_valid = 0; ps2_data = 0; key_consumed = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("reset_async", ex(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 check("reset_hold", ex(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].v, tbl[i].d, tbl[i].kc);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // reset mid-COLLECT after 4 accepted bytes aborts at once
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'hA0 + 8'(i), 0);
    check("four_bytes", ex(1, 3, 8'hA3, 4, 1, 0, 0));
    drive(0, 0, 8'h00, 0);
    #2 reset = 1'b0;
    #1 check("abort_async", ex(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'h21 + 8'(i), 0);
      check($sformatf("post_reset%0d", i), ex(0, 0, 0, 0, 0, 0, 0));
    end
    drive(0, 1, 8'h5A, 0);
    check("post_reset_enter", ex(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h3C, 0);
    check("restart_write", ex(1, 0, 8'h3C, 1, 1, 0, 0));
    drive(0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/keyload_ctrl.md
KEYLOAD_CTRL -- requirements
Module: keyload_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 ps2_data  input  8  scancode byte from the PS/2 receiver.
REQ-005 ps2_valid  input  1  one-cycle strobe qualifying ps2_data.
REQ-006 load_start  input  1  one-cycle pulse; begin (or restart) entry of a new 64-bit key.
REQ-007 key_consumed  input  1  one-cycle pulse from the cipher; key has been taken.
REQ-008 key_we  output  1  write enable to the 8-byte key register.
REQ-009 keyindex  output  3  byte slot written when key_we=1.
REQ-010 key_data  output  8  byte written when key_we=1.
REQ-011 key_count  output  4  bytes currently loaded, 0..8.
REQ-012 busy  output  1  high in COLLECT or SKIP.
REQ-013 key_ready  output  1  high in READY.
REQ-014 cipher_start  output  1  one-cycle pulse on entry to READY.

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, SKIP, READY.
REQ-016 IDLE: ps2_valid ignored; load_start -> COLLECT with key_count=0.
REQ-017 load_start in any state SHALL force COLLECT with key_count=0 and SHALL take priority over a same-cycle ps2_valid or key_consumed; the same-cycle byte is discarded.
REQ-018 COLLECT, ps2_valid with ps2_data=8'hF0 (break prefix): -> SKIP, no write, count unchanged.
REQ-019 COLLECT, ps2_data=8'hE0 (extended prefix): discarded, stay in COLLECT.
REQ-020 COLLECT, ps2_data=8'h66 (backspace): key_count-1 if key_count>0, else ignored; no write.
REQ-021 COLLECT, ps2_data=8'h5A (enter): if key_count=8 -> READY; if key_count<8 ignored.
REQ-022 COLLECT, any other byte with key_count<8: next cycle key_we=1, keyindex=key_count[2:0] (pre-increment), key_data=ps2_data; key_count increments in that same cycle.
REQ-023 COLLECT, any other byte with key_count=8: discarded; count stays 8 (no wrap).
REQ-024 key_we, keyindex, key_data SHALL be registered: asserted exactly one cycle after the accepted ps2_valid cycle, for one cycle; key_we=0 otherwise.
REQ-025 keyindex and key_data SHALL hold their last written values while key_we=0.
REQ-026 SKIP: the next ps2_valid byte (any value, including F0/E0/5A/66) is discarded and FSM returns to COLLECT.
REQ-027 Entry to READY: cipher_start=1 for exactly the first cycle in READY; key_ready=1 throughout READY.
REQ-028 READY: ps2_valid ignored; key_consumed -> IDLE with key_count=0 next cycle.
REQ-029 key_consumed outside READY SHALL be ignored.
REQ-030 Back-to-back ps2_valid on consecutive cycles SHALL each be processed; throughput one byte per cycle.
REQ-031 Backspace does not clear register contents; an overwritten slot is rewritten by the next accepted byte.

Reset
REQ-032 While reset=0 (asynchronous): state=IDLE, key_count=0, keyindex=0, key_data=0, key_we=0, busy=0, key_ready=0, cipher_start=0.
REQ-033 Reset asserted mid-COLLECT or in READY SHALL abort immediately; no key_we or cipher_start pulse after release until a new load_start.
REQ-034 First clock edge after reset release SHALL behave as IDLE.

Verification
REQ-035 load_start, then bytes 11,22,33,44,55,66h-excluded set (11,22,33,44,55,77,88,99), then 5A -> eight key_we pulses keyindex 0..7 with those data, key_count=8, one cipher_start, key_ready=1.
REQ-036 load_start, 1C, F0, 1C, 32 -> writes slot0=1C, slot1=32 only; key_count=2; busy=1.
REQ-037 load_start, 1C, 66, 66, 32 -> one decrement then ignored at 0; 32 written to slot 0; key_count=1.
REQ-038 load_start, 5 bytes, 5A -> no transition, key_ready=0; then 3 bytes, 5A -> READY; ninth data byte before 5A discarded.
REQ-039 In READY, key_consumed -> IDLE, key_count=0, key_ready=0; same-cycle load_start and key_consumed -> COLLECT.
REQ-040 reset=0 pulse after 4 accepted bytes -> all outputs 0 immediately; bytes sent after release without load_start produce no key_we.
